cordic_share_arbiter: RTL and testbench
=======================================

// Module: cordic_share_arbiter
// PURPOSE
// Round-robin arbiter/sequencer sharing one cordic_core (any MODE) among NUM_REQ
// function units (e.g. arctan, sin/cos, tan). Each requester posts a one-cycle start
// pulse with a Q2.14 operand; the arbiter buffers it, issues it to the CORDIC when
// granted, and routes the result back with a per-requester done pulse.
// PARAMETERS
// NUM_REQ         4    number of requesters (2..8)
// DW              16   operand/result width (Q2.14)
// TIMEOUT_CYCLES  64   watchdog limit on cordic_done wait (TIMEOUT_EN only)
// PORTS
// clk              in   1          system clock, rising edge
// rst_n            in   1          async active-low reset
// req_start        in   NUM_REQ    per-requester start pulse (1 cycle)
// req_operand      in   NUM_REQ*DW operand i at [i*DW +: DW], sampled with req_start[i]
// req_busy         out  NUM_REQ    requester i pending or in service
// resp_done        out  NUM_REQ    one-cycle completion pulse to owner
// resp_result      out  DW         cordic result_q14, valid while resp_done!=0
// resp_secondary   out  DW         cordic secondary_q14, valid while resp_done!=0
// resp_error       out  NUM_REQ    timeout flag, coincident with resp_done
// cordic_start     out  1          one-cycle start to cordic_core
// cordic_operand   out  DW         angle_q14 to cordic_core, stable ISSUE..RESPOND
// cordic_done      in   1          cordic_core done pulse
// cordic_result    in   DW         cordic_core result_q14
// cordic_secondary in   DW         cordic_core secondary_q14
// active_id        out  $clog2(NUM_REQ) index of requester in service
// busy             out  1          state != IDLE
// BEHAVIOUR
// - Reset: all outputs 0, pending=0, operand buffers 0, rr pointer=0, state=IDLE.
// - Buffering: req_start[i] with req_busy[i]=0 -> pending[i]<=1, opbuf[i]<=operand next
//   edge. req_start[i] while req_busy[i]=1 is ignored (no overwrite, no error).
// - req_busy[i] = pending[i] | (busy & active_id==i); goes 1 the cycle after req_start.
// - FSM: IDLE -> ISSUE -> WAIT -> RESPOND -> IDLE.
//   IDLE: if pending!=0, pick first set bit scanning from rr pointer upward (wrap at
//   NUM_REQ); latch active_id, cordic_operand<=opbuf[id], clear pending[id]; -> ISSUE.
//   ISSUE: cordic_start=1 for exactly this cycle; -> WAIT.
//   WAIT: on cordic_done, capture result/secondary into output regs; -> RESPOND.
//   RESPOND: resp_done[active_id]=1 one cycle; rr pointer <= active_id+1 (mod NUM_REQ);
//   -> IDLE.
// - Latency: req_start at cycle 0 with arbiter idle -> cordic_start at cycle 2;
//   resp_done 1 cycle after cordic_done is sampled. Back-to-back service gap: 1 IDLE cycle.
// - resp_result/resp_secondary hold last captured value between transactions.
// - Simultaneous: req_start[j] in RESPOND for j==active_id is accepted (busy drops in
//   the same cycle the new pending sets); cordic_done outside WAIT is ignored.
// - Fairness: with all requesters pending, service order is ptr, ptr+1, ... wrap.
// - Async reset mid-transaction: drops everything; no resp_done emitted for lost work.
// CONFIGURATION
// CORDIC_ARB_TIMEOUT_EN defined: WAIT counts cycles; at TIMEOUT_CYCLES without
//   cordic_done -> RESPOND with resp_error[active_id]=1, resp_result=0,
//   resp_secondary=0; a late cordic_done is ignored.
// Not defined: no counter, WAIT indefinitely; resp_error tied 0.
// TESTING
// 1 Single req: req_start[2], operand 16'h1000; cordic_done 11 cycles after start ->
//   cordic_start at cycle 2, cordic_operand=16'h1000, resp_done=4'b0100 w/ result.
// 2 All 4 pulse same cycle, ptr=0 -> service order 0,1,2,3; each resp_done routed once.
// 3 After serving 1, req 0 and 3 pending -> 3 served before 0 (wrap).
// 4 req_start[1] twice while busy, operand A then B -> only A issued, one resp_done[1].
// 5 Re-request in RESPOND cycle of same id -> accepted, served again next round.
// 6 TIMEOUT_EN, cordic_done withheld -> resp_done+resp_error at WAIT entry+64 cycles;
//   rst_n low mid-WAIT -> all outputs 0, no resp_done.

Source files
------------

// File: rtl/cordic_share_arbiter.sv
// -----------------------------------------------------------------------------
// cordic_share_arbiter
//
// Shares a single cordic_core among NUM_REQ function units. Each requester
// posts a one-cycle start pulse with a Q2.14 operand. The operand is buffered
// until the round-robin scan grants that requester. The arbiter then issues the
// operand to the CORDIC, waits for its done pulse, and returns the result with a
// one-cycle done pulse addressed to the owner.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   req_start         per-requester one-cycle start pulse
//   req_operand       operand i at [i*DW +: DW], sampled with req_start[i]
//   req_busy          requester i has a pending request or is in service
//   resp_done         one-cycle completion pulse to the owning requester
//   resp_result       captured cordic result, held between transactions
//   resp_secondary    captured cordic secondary output, held likewise
//   resp_error        timeout flag, coincident with resp_done
//   cordic_start      one-cycle start to the cordic_core
//   cordic_operand    operand presented to the cordic_core
//   cordic_done       cordic_core done pulse (only honoured while waiting)
//   cordic_result     cordic_core primary result
//   cordic_secondary  cordic_core secondary result
//   active_id         index of the requester in service
//   busy              arbiter is not idle
//
// Build option
//   CORDIC_ARB_TIMEOUT_EN  when defined, the wait for cordic_done is limited
//                          to TIMEOUT_CYCLES. On expiry the owner gets
//                          resp_done with resp_error set and zero results.
//                          When undefined, the arbiter waits indefinitely and
//                          resp_error is tied low.
// -----------------------------------------------------------------------------
module cordic_share_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DW             = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_start,
    input  logic [NUM_REQ*DW-1:0]      req_operand,
    output logic [NUM_REQ-1:0]         req_busy,
    output logic [NUM_REQ-1:0]         resp_done,
    output logic [DW-1:0]              resp_result,
    output logic [DW-1:0]              resp_secondary,
    output logic [NUM_REQ-1:0]         resp_error,
    output logic                       cordic_start,
    output logic [DW-1:0]              cordic_operand,
    input  logic                       cordic_done,
    input  logic [DW-1:0]              cordic_result,
    input  logic [DW-1:0]              cordic_secondary,
    output logic [$clog2(NUM_REQ)-1:0] active_id,
    output logic                       busy
);

    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] accept;
    logic [NUM_REQ-1:0] in_service;
    logic [DW-1:0]      opbuf [NUM_REQ];
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     grant_id;
    logic [IDW-1:0]     scan_id;
    logic               grant_found;

`ifdef CORDIC_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;
    logic          wait_expired;
    logic          timed_out;

    assign wait_expired = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`endif

    // Round-robin scan: the first pending requester at or above rr_ptr wins.
    // The scan wraps at NUM_REQ. Because NUM_REQ need not be a power of two,
    // the wrap is an explicit subtraction rather than a bit-width overflow.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_id     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (int'(rr_ptr) + k >= NUM_REQ) begin
                scan_id = IDW'(int'(rr_ptr) + k - NUM_REQ);
            end else begin
                scan_id = IDW'(int'(rr_ptr) + k);
            end
            if (!grant_found && pending[scan_id]) begin
                grant_found = 1'b1;
                grant_id    = scan_id;
            end
        end
    end

    // A requester is busy while it is pending or being served. A new start is
    // taken only from a requester that is not busy. The exception is the
    // RESPOND cycle, where the owner may re-request: its busy bit clears on the
    // same edge that its new pending bit sets.
    always_comb begin
        in_service = '0;
        if (busy) begin
            in_service[active_id] = 1'b1;
        end
        req_busy = pending | in_service;
        accept   = req_start & ~pending;
        if (state != RESPOND) begin
            accept = accept & ~in_service;
        end
    end

    // Operand buffers and pending flags. A pending bit is cleared when its
    // requester is granted in IDLE. Accept and grant cannot hit the same bit,
    // because accept requires the bit to be clear and grant requires it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                opbuf[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept[i]) begin
                    pending[i] <= 1'b1;
                    opbuf[i]   <= req_operand[i*DW +: DW];
                end else if (state == IDLE && grant_found && grant_id == IDW'(i)) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Sequencer next state: one transaction walks IDLE, ISSUE, WAIT, RESPOND
    // and then returns to IDLE. The return to IDLE leaves one gap cycle
    // between back-to-back services.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cordic_done) begin
                    state_nxt = RESPOND;
                end
`ifdef CORDIC_ARB_TIMEOUT_EN
                else if (wait_expired) begin
                    state_nxt = RESPOND;
                end
`endif
            end
            RESPOND: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decoded from the state. The done and error pulses are routed
    // to the owner only.
    always_comb begin
        busy         = (state != IDLE);
        cordic_start = (state == ISSUE);
        resp_done    = '0;
        resp_error   = '0;
        if (state == RESPOND) begin
            resp_done[active_id] = 1'b1;
`ifdef CORDIC_ARB_TIMEOUT_EN
            resp_error[active_id] = timed_out;
`endif
        end
    end

    // Transaction datapath. The operand and owner are latched at grant, the
    // CORDIC outputs are captured in WAIT, and the round-robin pointer moves
    // past the owner in RESPOND. A cordic_done outside WAIT has no effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_id      <= '0;
            cordic_operand <= '0;
            rr_ptr         <= '0;
            resp_result    <= '0;
            resp_secondary <= '0;
`ifdef CORDIC_ARB_TIMEOUT_EN
            wait_cnt       <= '0;
            timed_out      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        active_id      <= grant_id;
                        cordic_operand <= opbuf[grant_id];
                    end
                end
`ifdef CORDIC_ARB_TIMEOUT_EN
                ISSUE: begin
                    wait_cnt  <= '0;
                    timed_out <= 1'b0;
                end
`endif
                WAIT: begin
                    if (cordic_done) begin
                        resp_result    <= cordic_result;
                        resp_secondary <= cordic_secondary;
                    end
`ifdef CORDIC_ARB_TIMEOUT_EN
                    else if (wait_expired) begin
                        resp_result    <= '0;
                        resp_secondary <= '0;
                        timed_out      <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                RESPOND: begin
                    rr_ptr <= (active_id == IDW'(NUM_REQ - 1)) ? '0 : active_id + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cordic_share_arbiter
//
// Self-checking bench for cordic_share_arbiter with NUM_REQ=4 and DW=16.
//
// The bench also plays the cordic_core. For each issued operand it returns
// op ^ 16'h5A5A as the result and op + 16'h0101 as the secondary output.
//
// A transaction-level reference model predicts the DUT outputs every cycle.
// It tracks pending requests, the round-robin pointer, and the cycle numbers of
// start, done and respond for the request in service. These are derived from
// the grant rules and the documented latencies.
//
// Directed tables and sequences also compare the observed service order and
// the held results against hand-written constants.
// -----------------------------------------------------------------------------
module tb_cordic_share_arbiter;

    localparam int N   = 4;
    localparam int DW  = 16;
    localparam int TMO = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_start;
    logic [N*DW-1:0] req_operand;
    logic [N-1:0]    req_busy;
    logic [N-1:0]    resp_done;
    logic [DW-1:0]   resp_result;
    logic [DW-1:0]   resp_secondary;
    logic [N-1:0]    resp_error;
    logic            cordic_start;
    logic [DW-1:0]   cordic_operand;
    logic            cordic_done;
    logic [DW-1:0]   cordic_result;
    logic [DW-1:0]   cordic_secondary;
    logic [1:0]      active_id;
    logic            busy;

    cordic_share_arbiter #(
        .NUM_REQ       (N),
        .DW            (DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_start       (req_start),
        .req_operand     (req_operand),
        .req_busy        (req_busy),
        .resp_done       (resp_done),
        .resp_result     (resp_result),
        .resp_secondary  (resp_secondary),
        .resp_error      (resp_error),
        .cordic_start    (cordic_start),
        .cordic_operand  (cordic_operand),
        .cordic_done     (cordic_done),
        .cordic_result   (cordic_result),
        .cordic_secondary(cordic_secondary),
        .active_id       (active_id),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Scoreboard counters.
    int nchecks = 0;
    int nerrors = 0;

    // Reference model state.
    logic [N-1:0]  m_pend;
    logic [DW-1:0] m_op [N];
    int            m_ptr;
    int            m_srv;
    int            m_tstart;
    int            m_tdone;
    int            m_tresp;
    bit            m_tmo;
    logic [DW-1:0] m_res;
    logic [DW-1:0] m_sec;
    logic [DW-1:0] m_issued;
    int            c;
    int            next_delay;

    // Observed completions: owner id and the cycle it completed.
    int served_q[$];
    int served_c[$];

    typedef struct {
        logic [N-1:0]    mask;
        logic [N*DW-1:0] ops;
        int              delay;
        int              nsrv;
        logic [15:0]     order;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [DW-1:0] f_res(input logic [DW-1:0] op);
        return op ^ 16'h5A5A;
    endfunction

    function automatic logic [DW-1:0] f_sec(input logic [DW-1:0] op);
        return op + 16'h0101;
    endfunction

    function automatic logic [N*DW-1:0] pack4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [DW-1:0] cc, input logic [DW-1:0] d);
        return {d, cc, b, a};
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nchecks++;
        if (actual !== expected) begin
            nerrors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, c, actual, expected);
        end
    endtask

    task automatic model_reset();
        m_pend   = '0;
        for (int i = 0; i < N; i++) m_op[i] = '0;
        m_ptr    = 0;
        m_srv    = -1;
        m_tstart = -10;
        m_tdone  = -10;
        m_tresp  = -10;
        m_tmo    = 1'b0;
        m_res    = '0;
        m_sec    = '0;
        m_issued = '0;
        c        = 0;
    endtask

    // Runs one cycle, entered and left at a falling edge. The task first
    // checks the DUT outputs against the model. It then drives this cycle's
    // inputs (including the bench's own CORDIC response) and finally advances
    // the model across the next rising edge.
    task automatic apply_stimulus(input logic [N-1:0] starts, input logic [N*DW-1:0] ops, input bit spurious);
        logic [N-1:0] exp_done;
        logic [N-1:0] exp_err;
        logic [N-1:0] svc_mask;
        logic [N-1:0] acc;
        bit           in_svc;
        bit           in_wait;
        bit           done_now;
        bit           found;
        int           id;

        in_svc   = (m_srv >= 0) && (c >= m_tstart) && (c <= m_tresp);
        svc_mask = '0;
        if (in_svc) svc_mask[m_srv] = 1'b1;
        exp_done = (in_svc && c == m_tresp) ? svc_mask : '0;
        exp_err  = m_tmo ? exp_done : '0;

        check_output("resp_done", resp_done, exp_done);
        check_output("resp_error", resp_error, exp_err);
        check_output("busy", busy, in_svc);
        check_output("cordic_start", cordic_start, (m_srv >= 0) && (c == m_tstart));
        check_output("req_busy", req_busy, m_pend | svc_mask);
        check_output("resp_result", resp_result, m_res);
        check_output("resp_secondary", resp_secondary, m_sec);
        if (in_svc) begin
            check_output("active_id", active_id, m_srv);
            check_output("cordic_operand", cordic_operand, m_issued);
        end
        if (resp_done != '0) begin
            for (int i = 0; i < N; i++) begin
                if (resp_done[i]) served_q.push_back(i);
            end
            served_c.push_back(c);
        end

        in_wait          = (m_srv >= 0) && (c > m_tstart) && (c < m_tresp);
        done_now         = (m_srv >= 0) && (c == m_tdone);
        req_start        = starts;
        req_operand      = ops;
        cordic_done      = done_now || (spurious && !in_wait);
        cordic_result    = done_now ? f_res(m_issued) : 16'hDEAD;
        cordic_secondary = done_now ? f_sec(m_issued) : 16'hBEEF;

        acc = starts & ~m_pend;
        if (in_svc && c != m_tresp) acc = acc & ~svc_mask;
        if (done_now && c < m_tresp) begin
            m_res = f_res(m_issued);
            m_sec = f_sec(m_issued);
        end
        if (m_srv >= 0 && m_tmo && c == m_tresp - 1) begin
            m_res = '0;
            m_sec = '0;
        end
        if (m_srv < 0) begin
            if (m_pend != '0) begin
                found = 1'b0;
                id    = 0;
                for (int k = 0; k < N; k++) begin
                    if (!found && m_pend[(m_ptr + k) % N]) begin
                        found = 1'b1;
                        id    = (m_ptr + k) % N;
                    end
                end
                m_srv      = id;
                m_pend[id] = 1'b0;
                m_issued   = m_op[id];
                m_tstart   = c + 1;
                m_tdone    = m_tstart + next_delay;
`ifdef CORDIC_ARB_TIMEOUT_EN
                if (next_delay > TMO) begin
                    m_tmo   = 1'b1;
                    m_tresp = m_tstart + 1 + TMO;
                end else begin
                    m_tmo   = 1'b0;
                    m_tresp = m_tdone + 1;
                end
`else
                m_tmo   = 1'b0;
                m_tresp = m_tdone + 1;
`endif
            end
        end else if (c == m_tresp) begin
            m_ptr = (m_srv + 1) % N;
            m_srv = -1;
        end
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                m_pend[i] = 1'b1;
                m_op[i]   = ops[i*DW +: DW];
            end
        end

        @(posedge clk);
        c++;
        @(negedge clk);
    endtask

    // Idles until the model reports no pending or in-service work. The wait is
    // bounded by a cycle budget.
    task automatic drain();
        int g;
        g = 0;
        while ((m_srv >= 0 || m_pend != '0) && g < 3000) begin
            apply_stimulus('0, '0, 1'b0);
            g++;
        end
        check_output("drain_bound", (g < 3000), 1);
    endtask

    initial begin
        int s;
        int guard;
        logic [N-1:0] st;

        rst_n            = 1'b0;
        req_start        = '0;
        req_operand      = '0;
        cordic_done      = 1'b0;
        cordic_result    = '0;
        cordic_secondary = '0;
        model_reset();
        next_delay = 4;

        // Service-order vectors from a fresh reset (pointer at 0). Each order
        // nibble k holds the id expected as the k-th completion.
        vecs[0] = '{4'b1111, pack4(16'h0100, 16'h0200, 16'h0300, 16'h0400), 4, 4, 16'h3210};
        vecs[1] = '{4'b0100, pack4(16'h0000, 16'h0000, 16'h1000, 16'h0000), 11, 1, 16'h0002};
        vecs[2] = '{4'b0010, pack4(16'h0000, 16'h2222, 16'h0000, 16'h0000), 2, 1, 16'h0001};
        vecs[3] = '{4'b1001, pack4(16'h3333, 16'h0000, 16'h0000, 16'h4444), 3, 2, 16'h0003};
        vecs[4] = '{4'b0110, pack4(16'h0000, 16'h5555, 16'h6666, 16'h0000), 1, 2, 16'h0021};
        vecs[5] = '{4'b1111, pack4(16'h7777, 16'h8888, 16'h9999, 16'hAAAA), 6, 4, 16'h2103};

        repeat (2) @(negedge clk);
        check_output("rst_busy", busy, 0);
        check_output("rst_resp_done", resp_done, 0);
        check_output("rst_req_busy", req_busy, 0);
        check_output("rst_cordic_start", cordic_start, 0);
        check_output("rst_cordic_operand", cordic_operand, 0);
        check_output("rst_active_id", active_id, 0);
        check_output("rst_resp_result", resp_result, 0);
        rst_n = 1'b1;
        repeat (2) apply_stimulus('0, '0, 1'b0);

        // Table-driven service-order vectors
        for (int v = 0; v < 6; v++) begin
            served_q.delete();
            next_delay = vecs[v].delay;
            apply_stimulus(vecs[v].mask, vecs[v].ops, 1'b0);
            drain();
            check_output($sformatf("v%0d_count", v), served_q.size(), vecs[v].nsrv);
            for (int k = 0; k < vecs[v].nsrv; k++) begin
                if (k < served_q.size()) begin
                    check_output($sformatf("v%0d_order%0d", v, k), served_q[k], vecs[v].order[4*k +: 4]);
                end
            end
        end

        // Restart while busy: only the first operand is serviced
        served_q.delete();
        next_delay = 5;
        apply_stimulus(4'b0010, pack4(16'h0000, 16'h1234, 16'h0000, 16'h0000), 1'b0);
        apply_stimulus(4'b0010, pack4(16'h0000, 16'hBBBB, 16'h0000, 16'h0000), 1'b0);
        repeat (3) apply_stimulus('0, '0, 1'b0);
        apply_stimulus(4'b0010, pack4(16'h0000, 16'hCCCC, 16'h0000, 16'h0000), 1'b0);
        drain();
        check_output("t4_count", served_q.size(), 1);
        if (served_q.size() > 0) check_output("t4_owner", served_q[0], 1);
        check_output("t4_result", resp_result, 16'h486E);
        check_output("t4_secondary", resp_secondary, 16'h1335);

        // Re-request during the owner's own RESPOND cycle
        served_q.delete();
        next_delay = 3;
        apply_stimulus(4'b1000, pack4(16'h0000, 16'h0000, 16'h0000, 16'h0F0F), 1'b0);
        apply_stimulus('0, '0, 1'b0);
        guard = 0;
        while (c != m_tresp && guard < 100) begin
            apply_stimulus('0, '0, 1'b0);
            guard++;
        end
        check_output("t5_reach_respond", (guard < 100), 1);
        apply_stimulus(4'b1000, pack4(16'h0000, 16'h0000, 16'h0000, 16'h7070), 1'b0);
        drain();
        check_output("t5_count", served_q.size(), 2);
        if (served_q.size() > 1) begin
            check_output("t5_owner0", served_q[0], 3);
            check_output("t5_owner1", served_q[1], 3);
        end
        check_output("t5_result", resp_result, 16'h2A2A);

        // Randomized traffic, including stray cordic_done pulses outside WAIT
        for (int k = 0; k < 800; k++) begin
            st = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            next_delay = $urandom_range(1, 8);
            apply_stimulus(st, {$urandom, $urandom}, ($urandom_range(0, 11) == 0));
        end
        drain();

`ifdef CORDIC_ARB_TIMEOUT_EN
        // Withheld cordic_done: timeout response, then a late done is ignored
        served_q.delete();
        served_c.delete();
        next_delay = 1000;
        s = c;
        apply_stimulus(4'b0100, pack4(16'h0000, 16'h0000, 16'h2468, 16'h0000), 1'b0);
        drain();
        apply_stimulus('0, '0, 1'b1);
        repeat (2) apply_stimulus('0, '0, 1'b0);
        check_output("tmo_count", served_q.size(), 1);
        if (served_q.size() > 0) begin
            check_output("tmo_owner", served_q[0], 2);
            check_output("tmo_latency", served_c[0] - s, 67);
        end
        check_output("tmo_result", resp_result, 0);
        check_output("tmo_secondary", resp_secondary, 0);
`endif

        // Asynchronous reset mid-WAIT: everything clears, no completion follows
        next_delay = 30;
        apply_stimulus(4'b0001, pack4(16'h1111, 16'h0000, 16'h0000, 16'h0000), 1'b0);
        repeat (5) apply_stimulus('0, '0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_busy", busy, 0);
        check_output("mid_rst_resp_done", resp_done, 0);
        check_output("mid_rst_req_busy", req_busy, 0);
        check_output("mid_rst_cordic_start", cordic_start, 0);
        check_output("mid_rst_cordic_operand", cordic_operand, 0);
        check_output("mid_rst_resp_result", resp_result, 0);
        check_output("mid_rst_resp_secondary", resp_secondary, 0);
        check_output("mid_rst_active_id", active_id, 0);
        check_output("mid_rst_resp_error", resp_error, 0);
        model_reset();
        served_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) apply_stimulus('0, '0, 1'b0);
        check_output("post_rst_no_done", served_q.size(), 0);
        next_delay = 2;
        apply_stimulus(4'b0100, pack4(16'h0000, 16'h0000, 16'h0F00, 16'h0000), 1'b0);
        drain();
        check_output("post_rst_served", served_q.size(), 1);
        check_output("post_rst_result", resp_result, 16'h555A);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

    // Guards against a hung simulation.
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not reach its end, got hang, expected finish");
        $fatal(1, "[TB] global timeout");
    end

endmodule
